fc_vector_packer: RTL

- Producer side of the fully-connected layer's vector input.
- Accepts a serial stream of signed 16-bit features over a valid/ready handshake and packs them into an N_IN-wide parallel vector.
- Fires a one-cycle valid into the FC layer, then holds the vector stable until the layer's result-valid returns.
- Detects framing errors via a last marker and counts completed inferences.

---
 rtl/fc_vector_packer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fc_vector_packer.sv
// ---------------------------------------------------------------------------
// fc_vector_packer
//
// Producer side of the fully-connected layer's vector input. Serial signed
// 16-bit features arrive over a valid/ready handshake and are packed into an
// N_IN-wide register array. A complete frame raises vec_valid for one cycle.
// The vector is then held stable until the layer answers with result_valid,
// or until TIMEOUT cycles pass with no answer.
//
// Ports
//   clk           clock
//   reset         asynchronous, active-high reset
//   s_data        signed feature sample
//   s_valid       sample valid
//   s_last        final sample of a frame (qualified by s_valid)
//   s_ready       packer can accept a sample (FILL / DROP only)
//   vec_out       packed vector, element 0 is the first sample of the frame
//   vec_valid     one-cycle pulse into the FC layer
//   result_valid  FC layer done; only observed in WAIT
//   busy          high in FIRE and WAIT
//   frame_err     one-cycle pulse after a framing error
//   timeout_err   one-cycle pulse after WAIT gives up
//   frame_count   completed inferences, wraps at 16 bits
//
// State | meaning
// ------+---------------------------------------------------------------
// FILL  | accepting samples into vec_out[idx]
// DROP  | frame overran N_IN samples; discard until a sample with s_last
// FIRE  | single cycle, vec_valid asserted
// WAIT  | vector held, waiting up to TIMEOUT cycles for result_valid
// ---------------------------------------------------------------------------
module fc_vector_packer #(
    parameter int N_IN    = 169,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic signed [15:0] vec_out [0:N_IN-1],
    output logic               vec_valid,
    input  logic               result_valid,
    output logic               busy,
    output logic               frame_err,
    output logic               timeout_err,
    output logic [15:0]        frame_count
);

    localparam int IDX_W = (N_IN > 2) ? $clog2(N_IN) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
    // The counter holds the number of WAIT cycles already spent, so the
    // TIMEOUT-th WAIT cycle is the one where it reads TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_DROP = 2'd1,
        ST_FIRE = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             frame_err_nxt;
    logic             timeout_err_nxt;
    logic             count_inc;
    logic             write_en;
    logic             hs;
    logic             at_last_idx;

    // Ready is a pure state decode. It is gated by reset so that nothing can
    // be accepted while the block is held in reset.
    assign s_ready     = !reset && ((state == ST_FILL) || (state == ST_DROP));
    assign busy        = (state == ST_FIRE) || (state == ST_WAIT);
    assign vec_valid   = (state == ST_FIRE);
    assign hs          = s_valid && s_ready;
    assign at_last_idx = (idx == IDX_LAST);

    // ------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_FILL;
            idx         <= '0;
            wait_cnt    <= '0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            wait_cnt    <= wait_cnt_nxt;
            frame_err   <= frame_err_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        wait_cnt_nxt    = wait_cnt;
        frame_err_nxt   = 1'b0;
        timeout_err_nxt = 1'b0;
        count_inc       = 1'b0;
        write_en        = 1'b0;

        case (state)
            ST_FILL: begin
                if (hs) begin
                    write_en = 1'b1;
                    if (s_last) begin
                        idx_nxt = '0;
                        if (at_last_idx) begin
                            state_nxt = ST_FIRE;
                        end else begin
                            // Early last: the partial frame is abandoned and
                            // the next sample starts a fresh frame.
                            frame_err_nxt = 1'b1;
                        end
                    end else if (at_last_idx) begin
                        // Vector full but no last marker: resynchronise on
                        // the next s_last without further error pulses.
                        idx_nxt       = '0;
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_DROP;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end

            ST_DROP: begin
                if (hs && s_last) begin
                    state_nxt = ST_FILL;
                end
            end

            ST_FIRE: begin
                wait_cnt_nxt = '0;
                state_nxt    = ST_WAIT;
            end

            ST_WAIT: begin
                // A response on the final allowed cycle still counts.
                if (result_valid) begin
                    count_inc    = 1'b1;
                    wait_cnt_nxt = '0;
                    state_nxt    = ST_FILL;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout_err_nxt = 1'b1;
                    wait_cnt_nxt    = '0;
                    state_nxt       = ST_FILL;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = ST_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Vector register array: written only on FILL handshakes, so it is
    // naturally frozen through FIRE and WAIT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) begin
                vec_out[i] <= '0;
            end
        end else if (write_en) begin
            vec_out[idx] <= s_data;
        end
    end

    // ------------------------------------------------------------------
    // Completed-inference counter, wraps naturally at 16 bits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (count_inc) begin
            frame_count <= frame_count + 16'd1;
        end
    end

endmodule
